csr_file: RTL and testbench
===========================

# csr_file

Parametrised machine-mode CSR file for the tartaruga core, sitting in decode and feeding execute and the trap/PC-redirect logic. It generalises the basic mepc/mcause/mtval store to a full M-mode trap set (mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval), atomic CSRRW/CSRRS/CSRRC semantics, mret handling, interrupt gating and optional 64-bit performance counters. Reads are combinational; all state updates occur on the clock edge with a fixed priority.

## Interface

- XLEN, 32: register width; 32 or 64 only.
- MTVEC_RESET, 'h0000_0100: reset value of mtvec, mode field 0.
- HART_ID, 0: value returned by mhartid.

- clk_i  in  1  clock
- rstn_i  in  1  asynchronous, active-low reset
- csr_req_i  in  1  CSR instruction valid this cycle
- csr_op_i  in  2  csr_op_t: CSR_RW, CSR_RS, CSR_RC
- csr_wr_i  in  1  instruction writes (0 for CSRRS/CSRRC with rs1=x0/uimm=0)
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  operand (rs1 or zero-extended uimm)
- csr_rdata_o  out  XLEN  old CSR value
- csr_illegal_o  out  1  illegal CSR access
- xcpt_i  in  1  take trap this cycle
- xcpt_irq_i  in  1  trap is an interrupt
- xcpt_code_i  in  5  cause code
- xcpt_pc_i  in  XLEN  PC of trapping instruction
- xcpt_value_i  in  XLEN  mtval value
- mret_i  in  1  mret commits this cycle
- instr_retired_i  in  1  one instruction retired
- irq_ext_i  in  1  external interrupt level (MEIP)
- irq_timer_i  in  1  timer interrupt level (MTIP)
- irq_pending_o  out  1  enabled interrupt pending
- trap_vector_o  out  XLEN  trap target PC
- epc_o  out  XLEN  mepc, mret target

## Operation

- Implemented: mstatus (MIE bit 3, MPIE bit 7, MPP bits 12:11 read as 2'b11), misa (RO, RV32I/RV64I), mhartid (RO), mie (MEIE 11, MTIE 7), mip (RO, mirrors inputs), mtvec, mscratch, mepc (bits 1:0 read 0), mcause, mtval.
- Write value: RW -> wdata; RS -> old | wdata; RC -> old & ~wdata. Only WARL bits stored; others read 0.
- csr_illegal_o = csr_req_i and (address not implemented, or csr_wr_i on a read-only CSR, or address bits 11:10 = 2'b11 with csr_wr_i). Illegal access writes nothing; csr_rdata_o = 0.
- csr_rdata_o = 0 when csr_req_i = 0.
- Trap (xcpt_i): mepc<=xcpt_pc_i; mcause<={xcpt_irq_i, zeros, xcpt_code_i}; mtval<=xcpt_value_i (0 for interrupts); MPIE<=MIE; MIE<=0.
- mret_i: MIE<=MPIE; MPIE<=1.
- Priority per edge: xcpt_i > mret_i > CSR write. A CSR write in a trap cycle is discarded.
- trap_vector_o: mtvec mode 0 -> base; mode 1 and xcpt_irq_i -> base + 4*xcpt_code_i; modes 2/3 treated as 0.
- irq_pending_o = MIE & ((MEIP & MEIE) | (MTIP & MTIE)), combinational from current state.

## Timing

- Reset: mtvec=MTVEC_RESET, all other stored state 0, counters 0. Outputs during reset: csr_rdata_o=0, csr_illegal_o=0, irq_pending_o=0, epc_o=0, trap_vector_o=MTVEC_RESET.
- Read latency 0 (same cycle); write visible to a read in the next cycle.
- Read-modify-write is atomic: rdata is the pre-edge value.
- Reset asserted mid-operation clears state immediately; pending write lost.
- mip follows irq inputs with 0 cycles (no internal latching).

## Configuration

- CSR_COUNTERS_EN defined: mcycle (every cycle) and minstret (on instr_retired_i), 64-bit, wrap 2^64-1 -> 0; XLEN=32 exposes mcycle/mcycleh, minstret/minstreth; software write in a cycle wins over increment for that half, other half still carries normally from pre-write value.
- Undefined: counters absent, their addresses illegal.

## Structure

- Package tartaruga_pkg: csr_op_t, mstatus bit positions, mtvec mode enum. riscv_pkg: all CSR_*_ADDR constants, cause codes.
- Sub-module csr_counter: 64-bit counter with increment enable, lo/hi write ports; instantiated twice under CSR_COUNTERS_EN.

## Test plan

- CSRRW mscratch 0xDEADBEEF, then CSRRS 0x0000_00F0, then CSRRC 0x0000_000F -> rdata 0, 0xDEADBEEF, 0xDEADBEFF; final 0xDEADBEF0.
- Set MIE, xcpt_i code 2, pc 0x80, value 0x1234 -> mepc 0x80, mcause 2, mtval 0x1234, MIE 0, MPIE 1; mret -> MIE 1.
- mtvec=0x201 (vectored), MIE/MTIE set, irq_timer_i=1 -> irq_pending_o=1; trap irq code 7 -> trap_vector_o 0x21C, mcause 0x8000_0007.
- Write to mhartid, read unknown 0x7C0 -> csr_illegal_o=1, no state change.
- xcpt_i with simultaneous CSRRW mepc 0x40 -> mepc = xcpt_pc_i.
- CSR_COUNTERS_EN: preload mcycle 0xFFFF_FFFF -> next cycle mcycle 0, mcycleh +1.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - architectural CSR addresses, interrupt bit positions and cause codes
package riscv_pkg;

  localparam logic [11:0] CSR_MSTATUS_ADDR   = 12'h300;
  localparam logic [11:0] CSR_MISA_ADDR      = 12'h301;
  localparam logic [11:0] CSR_MIE_ADDR       = 12'h304;
  localparam logic [11:0] CSR_MTVEC_ADDR     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH_ADDR  = 12'h340;
  localparam logic [11:0] CSR_MEPC_ADDR      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE_ADDR    = 12'h342;
  localparam logic [11:0] CSR_MTVAL_ADDR     = 12'h343;
  localparam logic [11:0] CSR_MIP_ADDR       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE_ADDR    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET_ADDR  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH_ADDR   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH_ADDR = 12'hB82;
  localparam logic [11:0] CSR_MHARTID_ADDR   = 12'hF14;

  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT    = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M       = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_TIMER_M   = 5'd7;
  localparam logic [4:0] CAUSE_IRQ_EXT_M     = 5'd11;

endpackage

// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - core-local CSR types: operation encoding, mstatus bits, mtvec modes
package tartaruga_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'd1,
    CSR_RS = 2'd2,
    CSR_RC = 2'd3
  } csr_op_t;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_t;

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - 64-bit event counter with independent lo/hi software write ports
module csr_counter (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata_lo,
  input  logic [31:0] i_wdata_hi,
  output logic [63:0] o_count
);

  logic [63:0] r_count;
  logic [63:0] w_inc;

  // Carry into the high half always comes from the pre-write value.
  assign w_inc   = r_count + {63'd0, i_inc};
  assign o_count = r_count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else begin
      r_count[31:0]  <= i_wr_lo ? i_wdata_lo : w_inc[31:0];
      r_count[63:32] <= i_wr_hi ? i_wdata_hi : w_inc[63:32];
    end
  end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - M-mode CSR file with trap/mret handling; CSR_COUNTERS_EN adds mcycle/minstret
module csr_file
  import tartaruga_pkg::*;
  import riscv_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 'h0000_0100,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            csr_req_i,
  input  csr_op_t         csr_op_i,
  input  logic            csr_wr_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            xcpt_i,
  input  logic            xcpt_irq_i,
  input  logic [4:0]      xcpt_code_i,
  input  logic [XLEN-1:0] xcpt_pc_i,
  input  logic [XLEN-1:0] xcpt_value_i,
  input  logic            mret_i,
  input  logic            instr_retired_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  output logic            irq_pending_o,
  output logic [XLEN-1:0] trap_vector_o,
  output logic [XLEN-1:0] epc_o
);

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic            r_mie_meie;
  logic            r_mie_mtie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic            r_mcause_irq;
  logic [4:0]      r_mcause_code;
  logic [XLEN-1:0] r_mtval;

  logic [XLEN-1:0] w_mstatus, w_misa, w_mie, w_mip, w_mcause;
  logic [XLEN-1:0] w_old, w_new;
  logic            w_impl, w_ro, w_illegal, w_we;
  logic [XLEN-1:0] w_tvec_base;

  always_comb begin
    w_mstatus = '0;
    w_mstatus[MSTATUS_MIE_BIT]                        = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE_BIT]                       = r_mstatus_mpie;
    w_mstatus[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]      = 2'b11;
    w_misa = '0;
    w_misa[XLEN-1 -: 2] = (XLEN == 64) ? 2'd2 : 2'd1;
    w_misa[8]           = 1'b1;
    w_mie = '0;
    w_mie[MIP_MEIP_BIT] = r_mie_meie;
    w_mie[MIP_MTIP_BIT] = r_mie_mtie;
    w_mip = '0;
    w_mip[MIP_MEIP_BIT] = irq_ext_i;
    w_mip[MIP_MTIP_BIT] = irq_timer_i;
    w_mcause = '0;
    w_mcause[XLEN-1] = r_mcause_irq;
    w_mcause[4:0]    = r_mcause_code;
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret, w_new64;
  logic        w_wr_cyc_lo, w_wr_cyc_hi, w_wr_ins_lo, w_wr_ins_hi;
  logic [31:0] w_wdata_hi;

  assign w_new64     = 64'(w_new);
  assign w_wdata_hi  = (XLEN == 64) ? w_new64[63:32] : w_new64[31:0];
  assign w_wr_cyc_lo = w_we && csr_addr_i == CSR_MCYCLE_ADDR;
  assign w_wr_ins_lo = w_we && csr_addr_i == CSR_MINSTRET_ADDR;
  assign w_wr_cyc_hi = (XLEN == 64) ? w_wr_cyc_lo : (w_we && csr_addr_i == CSR_MCYCLEH_ADDR);
  assign w_wr_ins_hi = (XLEN == 64) ? w_wr_ins_lo : (w_we && csr_addr_i == CSR_MINSTRETH_ADDR);

  csr_counter u_mcycle (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .i_inc      (1'b1),
    .i_wr_lo    (w_wr_cyc_lo),
    .i_wr_hi    (w_wr_cyc_hi),
    .i_wdata_lo (w_new64[31:0]),
    .i_wdata_hi (w_wdata_hi),
    .o_count    (w_mcycle)
  );

  csr_counter u_minstret (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .i_inc      (instr_retired_i),
    .i_wr_lo    (w_wr_ins_lo),
    .i_wr_hi    (w_wr_ins_hi),
    .i_wdata_lo (w_new64[31:0]),
    .i_wdata_hi (w_wdata_hi),
    .o_count    (w_minstret)
  );
`else
  logic w_unused_retired;
  assign w_unused_retired = instr_retired_i;
`endif

  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    w_ro   = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS_ADDR:  w_old = w_mstatus;
      CSR_MISA_ADDR:     begin w_old = w_misa;  w_ro = 1'b1; end
      CSR_MHARTID_ADDR:  begin w_old = HART_ID; w_ro = 1'b1; end
      CSR_MIE_ADDR:      w_old = w_mie;
      CSR_MIP_ADDR:      begin w_old = w_mip;   w_ro = 1'b1; end
      CSR_MTVEC_ADDR:    w_old = r_mtvec;
      CSR_MSCRATCH_ADDR: w_old = r_mscratch;
      CSR_MEPC_ADDR:     w_old = r_mepc;
      CSR_MCAUSE_ADDR:   w_old = w_mcause;
      CSR_MTVAL_ADDR:    w_old = r_mtval;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE_ADDR:    w_old = XLEN'(w_mcycle);
      CSR_MINSTRET_ADDR:  w_old = XLEN'(w_minstret);
      CSR_MCYCLEH_ADDR:   begin w_old = XLEN'(w_mcycle[63:32]);   w_impl = (XLEN == 32); end
      CSR_MINSTRETH_ADDR: begin w_old = XLEN'(w_minstret[63:32]); w_impl = (XLEN == 32); end
`endif
      default:           w_impl = 1'b0;
    endcase
  end

  always_comb begin
    w_new = csr_wdata_i;
    case (csr_op_i)
      CSR_RS:  w_new = w_old | csr_wdata_i;
      CSR_RC:  w_new = w_old & ~csr_wdata_i;
      default: w_new = csr_wdata_i;
    endcase
  end

  assign w_illegal     = csr_req_i & (~w_impl | (csr_wr_i & (w_ro | (csr_addr_i[11:10] == 2'b11))));
  assign w_we          = csr_req_i & csr_wr_i & ~w_illegal & ~xcpt_i;
  assign csr_illegal_o = rstn_i & w_illegal;
  assign csr_rdata_o   = (rstn_i && csr_req_i && !w_illegal) ? w_old : '0;

  assign irq_pending_o = r_mstatus_mie & ((irq_ext_i & r_mie_meie) | (irq_timer_i & r_mie_mtie));
  assign epc_o         = r_mepc;
  assign w_tvec_base   = {r_mtvec[XLEN-1:2], 2'b00};
  // Modes 2/3 are reserved and fall back to direct.
  assign trap_vector_o = (mtvec_mode_t'(r_mtvec[1:0]) == MTVEC_VECTORED && xcpt_irq_i)
                         ? w_tvec_base + XLEN'({xcpt_code_i, 2'b00}) : w_tvec_base;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mtvec        <= MTVEC_RESET;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause_irq   <= 1'b0;
      r_mcause_code  <= '0;
      r_mtval        <= '0;
    end else begin
      if (xcpt_i) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_we && csr_addr_i == CSR_MSTATUS_ADDR) begin
        r_mstatus_mie  <= w_new[MSTATUS_MIE_BIT];
        r_mstatus_mpie <= w_new[MSTATUS_MPIE_BIT];
      end

      if (xcpt_i) begin
        r_mepc        <= {xcpt_pc_i[XLEN-1:2], 2'b00};
        r_mcause_irq  <= xcpt_irq_i;
        r_mcause_code <= xcpt_code_i;
        r_mtval       <= xcpt_irq_i ? '0 : xcpt_value_i;
      end else begin
        if (w_we && csr_addr_i == CSR_MEPC_ADDR)   r_mepc <= {w_new[XLEN-1:2], 2'b00};
        if (w_we && csr_addr_i == CSR_MCAUSE_ADDR) begin
          r_mcause_irq  <= w_new[XLEN-1];
          r_mcause_code <= w_new[4:0];
        end
        if (w_we && csr_addr_i == CSR_MTVAL_ADDR)  r_mtval <= w_new;
      end

      if (w_we && csr_addr_i == CSR_MIE_ADDR) begin
        r_mie_meie <= w_new[MIP_MEIP_BIT];
        r_mie_mtie <= w_new[MIP_MTIP_BIT];
      end
      if (w_we && csr_addr_i == CSR_MTVEC_ADDR)    r_mtvec    <= w_new;
      if (w_we && csr_addr_i == CSR_MSCRATCH_ADDR) r_mscratch <= w_new;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file
module tb_csr_file;
  import tartaruga_pkg::*;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        csr_req = 1'b0;
  csr_op_t     csr_op = CSR_RW;
  logic        csr_wr = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        xcpt = 1'b0;
  logic        xcpt_irq = 1'b0;
  logic [4:0]  xcpt_code = '0;
  logic [31:0] xcpt_pc = '0;
  logic [31:0] xcpt_value = '0;
  logic        mret = 1'b0;
  logic        retired = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_pending;
  logic [31:0] trap_vector;
  logic [31:0] epc;

  int n_checks = 0;
  int n_fail = 0;

  csr_file #(.XLEN(32), .MTVEC_RESET(32'h0000_0100), .HART_ID(32'h0)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .csr_req_i(csr_req), .csr_op_i(csr_op), .csr_wr_i(csr_wr),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .xcpt_i(xcpt), .xcpt_irq_i(xcpt_irq), .xcpt_code_i(xcpt_code),
    .xcpt_pc_i(xcpt_pc), .xcpt_value_i(xcpt_value),
    .mret_i(mret), .instr_retired_i(retired),
    .irq_ext_i(irq_ext), .irq_timer_i(irq_timer),
    .irq_pending_o(irq_pending), .trap_vector_o(trap_vector), .epc_o(epc)
  );

  always #5 clk = ~clk;

  task automatic do_csr(input csr_op_t op, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic ill);
    csr_req = 1'b1; csr_op = op; csr_wr = wr; csr_addr = addr; csr_wdata = wd;
    #2;
    rd = csr_rdata; ill = csr_illegal;
    @(posedge clk); #1;
    csr_req = 1'b0; csr_wr = 1'b0; csr_wdata = '0;
  endtask

  task automatic rd_csr(input logic [11:0] addr, output logic [31:0] rd);
    logic ill;
    do_csr(CSR_RS, 1'b0, addr, 32'h0, rd, ill);
  endtask

  task automatic wr_csr(input logic [11:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic ill;
    do_csr(CSR_RW, 1'b1, addr, wd, rd, ill);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    csr_req = 1'b1; csr_wr = 1'b1; csr_addr = 12'h7C0; irq_ext = 1'b1; irq_timer = 1'b1;
    @(posedge clk); #2;
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got=%b exp=0", csr_illegal); end
    csr_addr = CSR_MTVEC_ADDR; #1;
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", csr_rdata); end
    n_checks++; if (trap_vector !== 32'h100) begin n_fail++; $display("FAIL rst_tvec got=%h exp=100", trap_vector); end
    n_checks++; if (epc !== 32'h0 || irq_pending !== 1'b0) begin n_fail++; $display("FAIL rst_epc_irq got=%h/%b exp=0/0", epc, irq_pending); end
    csr_req = 1'b0; csr_wr = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    rd_csr(CSR_MTVEC_ADDR, d);
    n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL rst_mtvec got=%h exp=100", d); end
    rd_csr(CSR_MSTATUS_ADDR, d);
    n_checks++; if (d !== 32'h1800) begin n_fail++; $display("FAIL rst_mstatus got=%h exp=1800", d); end
    rd_csr(CSR_MISA_ADDR, d);
    n_checks++; if (d !== 32'h4000_0100) begin n_fail++; $display("FAIL misa got=%h exp=40000100", d); end
  endtask

  task automatic test_rmw;
    logic [31:0] d;
    logic ill;
    do_csr(CSR_RW, 1'b1, CSR_MSCRATCH_ADDR, 32'hDEAD_BEEF, d, ill);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmw_rw got=%h exp=0", d); end
    do_csr(CSR_RS, 1'b1, CSR_MSCRATCH_ADDR, 32'h0000_00F0, d, ill);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rmw_rs got=%h exp=deadbeef", d); end
    do_csr(CSR_RC, 1'b1, CSR_MSCRATCH_ADDR, 32'h0000_000F, d, ill);
    n_checks++; if (d !== 32'hDEAD_BEFF) begin n_fail++; $display("FAIL rmw_rc got=%h exp=deadbeff", d); end
    rd_csr(CSR_MSCRATCH_ADDR, d);
    n_checks++; if (d !== 32'hDEAD_BEF0) begin n_fail++; $display("FAIL rmw_final got=%h exp=deadbef0", d); end
  endtask

  task automatic test_trap;
    logic [31:0] d;
    logic ill;
    do_csr(CSR_RS, 1'b1, CSR_MSTATUS_ADDR, 32'h8, d, ill);
    xcpt = 1'b1; xcpt_irq = 1'b0; xcpt_code = 5'd2; xcpt_pc = 32'h80; xcpt_value = 32'h1234;
    #1;
    n_checks++; if (trap_vector !== 32'h100) begin n_fail++; $display("FAIL trap_vec_direct got=%h exp=100", trap_vector); end
    @(posedge clk); #1; xcpt = 1'b0;
    n_checks++; if (epc !== 32'h80) begin n_fail++; $display("FAIL trap_epc got=%h exp=80", epc); end
    rd_csr(CSR_MCAUSE_ADDR, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL trap_mcause got=%h exp=2", d); end
    rd_csr(CSR_MTVAL_ADDR, d);
    n_checks++; if (d !== 32'h1234) begin n_fail++; $display("FAIL trap_mtval got=%h exp=1234", d); end
    rd_csr(CSR_MSTATUS_ADDR, d);
    n_checks++; if (d !== 32'h1880) begin n_fail++; $display("FAIL trap_mstatus got=%h exp=1880", d); end
    mret = 1'b1; @(posedge clk); #1; mret = 1'b0;
    rd_csr(CSR_MSTATUS_ADDR, d);
    n_checks++; if (d !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus got=%h exp=1888", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    wr_csr(CSR_MTVEC_ADDR, 32'h201);
    wr_csr(CSR_MIE_ADDR, 32'h80);
    irq_ext = 1'b1; #1;
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_ext_masked got=%b exp=0", irq_pending); end
    irq_ext = 1'b0; irq_timer = 1'b1; #1;
    n_checks++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_timer_pending got=%b exp=1", irq_pending); end
    rd_csr(CSR_MIP_ADDR, d);
    n_checks++; if (d !== 32'h80) begin n_fail++; $display("FAIL mip got=%h exp=80", d); end
    xcpt = 1'b1; xcpt_irq = 1'b1; xcpt_code = 5'd7; xcpt_pc = 32'h100; xcpt_value = 32'h55;
    #1;
    n_checks++; if (trap_vector !== 32'h21C) begin n_fail++; $display("FAIL irq_vector got=%h exp=21c", trap_vector); end
    @(posedge clk); #1; xcpt = 1'b0;
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_after_trap got=%b exp=0", irq_pending); end
    rd_csr(CSR_MCAUSE_ADDR, d);
    n_checks++; if (d !== 32'h8000_0007) begin n_fail++; $display("FAIL irq_mcause got=%h exp=80000007", d); end
    rd_csr(CSR_MTVAL_ADDR, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL irq_mtval got=%h exp=0", d); end
    irq_timer = 1'b0; xcpt_irq = 1'b0;
    mret = 1'b1; @(posedge clk); #1; mret = 1'b0;
  endtask

  task automatic test_illegal;
    logic [31:0] d;
    logic ill;
    do_csr(CSR_RW, 1'b1, CSR_MHARTID_ADDR, 32'h5, d, ill);
    n_checks++; if (ill !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL ill_mhartid_wr got=%b/%h exp=1/0", ill, d); end
    do_csr(CSR_RS, 1'b0, 12'h7C0, 32'h0, d, ill);
    n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL ill_unknown got=%b exp=1", ill); end
    do_csr(CSR_RW, 1'b1, CSR_MISA_ADDR, 32'h0, d, ill);
    n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL ill_misa_wr got=%b exp=1", ill); end
    do_csr(CSR_RS, 1'b0, CSR_MHARTID_ADDR, 32'h0, d, ill);
    n_checks++; if (ill !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL mhartid_rd got=%b/%h exp=0/0", ill, d); end
    rd_csr(CSR_MISA_ADDR, d);
    n_checks++; if (d !== 32'h4000_0100) begin n_fail++; $display("FAIL misa_unchanged got=%h exp=40000100", d); end
    csr_addr = CSR_MSCRATCH_ADDR; csr_req = 1'b0; #1;
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL noreq_rdata got=%h exp=0", csr_rdata); end
    rd_csr(CSR_MSCRATCH_ADDR, d);
    n_checks++; if (d !== 32'hDEAD_BEF0) begin n_fail++; $display("FAIL ill_no_change got=%h exp=deadbef0", d); end
  endtask

  task automatic test_priority;
    logic [31:0] d;
    csr_req = 1'b1; csr_op = CSR_RW; csr_wr = 1'b1; csr_addr = CSR_MEPC_ADDR; csr_wdata = 32'h40;
    xcpt = 1'b1; xcpt_irq = 1'b0; xcpt_code = 5'd3; xcpt_pc = 32'h90; xcpt_value = 32'h0;
    @(posedge clk); #1;
    xcpt = 1'b0; csr_req = 1'b0; csr_wr = 1'b0;
    rd_csr(CSR_MEPC_ADDR, d);
    n_checks++; if (d !== 32'h90) begin n_fail++; $display("FAIL prio_mepc got=%h exp=90", d); end
    wr_csr(CSR_MEPC_ADDR, 32'h43);
    rd_csr(CSR_MEPC_ADDR, d);
    n_checks++; if (d !== 32'h40) begin n_fail++; $display("FAIL mepc_align got=%h exp=40", d); end
    wr_csr(CSR_MTVEC_ADDR, 32'h202);
    xcpt_irq = 1'b1; xcpt_code = 5'd3; #1;
    n_checks++; if (trap_vector !== 32'h200) begin n_fail++; $display("FAIL tvec_mode2 got=%h exp=200", trap_vector); end
    xcpt_irq = 1'b0;
  endtask

  task automatic test_counters;
    logic [31:0] d;
`ifdef CSR_COUNTERS_EN
    wr_csr(CSR_MCYCLEH_ADDR, 32'h0);
    wr_csr(CSR_MCYCLE_ADDR, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rd_csr(CSR_MCYCLE_ADDR, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap got=%h exp=0", d); end
    rd_csr(CSR_MCYCLEH_ADDR, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL mcycleh_carry got=%h exp=1", d); end
    wr_csr(CSR_MINSTRET_ADDR, 32'h5);
    retired = 1'b1; @(posedge clk); @(posedge clk); #1; retired = 1'b0;
    rd_csr(CSR_MINSTRET_ADDR, d);
    n_checks++; if (d !== 32'h7) begin n_fail++; $display("FAIL minstret got=%h exp=7", d); end
`else
    logic ill;
    do_csr(CSR_RS, 1'b0, CSR_MCYCLE_ADDR, 32'h0, d, ill);
    n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL mcycle_absent got=%b exp=1", ill); end
`endif
  endtask

  task automatic test_mid_reset;
    logic [31:0] d;
    wr_csr(CSR_MSCRATCH_ADDR, 32'h1111);
    csr_req = 1'b1; csr_op = CSR_RW; csr_wr = 1'b1; csr_addr = CSR_MSCRATCH_ADDR; csr_wdata = 32'h2222;
    #2; rstn = 1'b0; #1;
    n_checks++; if (epc !== 32'h0 || trap_vector !== 32'h100) begin n_fail++; $display("FAIL midrst_async got=%h/%h exp=0/100", epc, trap_vector); end
    @(posedge clk); #1;
    csr_req = 1'b0; csr_wr = 1'b0; rstn = 1'b1;
    rd_csr(CSR_MSCRATCH_ADDR, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_mscratch got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_rmw();
    test_trap();
    test_irq();
    test_illegal();
    test_priority();
    test_counters();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
